// File: rtl/fifo_lane.sv
// Single-lane circular FIFO with registered read port, occupancy and
// threshold flags, and a sticky overflow indicator.
module fifo_lane #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int PTR_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  validIn,
  input  logic                  pop,
  input  logic [PTR_WIDTH:0]    afThresh,
  input  logic [PTR_WIDTH:0]    aeThresh,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  validOut,
  output logic                  full,
  output logic                  empty,
  output logic                  almostFull,
  output logic                  almostEmpty,
  output logic [PTR_WIDTH:0]    count,
  output logic                  error
);

  localparam logic [PTR_WIDTH:0] FULL_CNT = (PTR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH:0]    count_q, count_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q;
  logic                  full_q, empty_q;
  logic                  af_q, ae_q;
  logic                  err_q, err_d;
  logic                  push_acc, pop_acc;

  always_comb begin
    pop_acc  = pop && (count_q != '0);
    // A full FIFO still accepts a push when a pop frees a slot this cycle
    push_acc = validIn && ((count_q != FULL_CNT) || pop_acc);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    data_d   = data_q;
    err_d    = err_q || (validIn && !push_acc);
    if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      data_d   = mem_q[rd_ptr_q];
    end
    unique case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= (afThresh == '0);
      ae_q     <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      valid_q  <= pop_acc;
      full_q   <= (count_d == FULL_CNT);
      empty_q  <= (count_d == '0);
      af_q     <= (count_d >= afThresh);
      ae_q     <= (count_d <= aeThresh);
      err_q    <= err_d;
    end
  end

  // Storage is not cleared; reads only reach entries written since reset
  always_ff @(posedge clk) begin
    if (push_acc && !reset) mem_q[wr_ptr_q] <= dataIn;
  end

  assign dataOut     = data_q;
  assign validOut    = valid_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign almostFull  = af_q;
  assign almostEmpty = ae_q;
  assign count       = count_q;
  assign error       = err_q;

endmodule

// File: tb/tb_fifo_lane.sv
// Directed self-checking bench for fifo_lane.
module tb_fifo_lane;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] dataIn;
  logic       validIn;
  logic       pop;
  logic [2:0] afThresh;
  logic [2:0] aeThresh;
  logic [7:0] dataOut;
  logic       validOut;
  logic       full;
  logic       empty;
  logic       almostFull;
  logic       almostEmpty;
  logic [2:0] count;
  logic       error;

  int n_run  = 0;
  int n_fail = 0;

  fifo_lane #(
    .DATA_WIDTH(8),
    .DEPTH(4),
    .PTR_WIDTH(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .dataIn(dataIn),
    .validIn(validIn),
    .pop(pop),
    .afThresh(afThresh),
    .aeThresh(aeThresh),
    .dataOut(dataOut),
    .validOut(validOut),
    .full(full),
    .empty(empty),
    .almostFull(almostFull),
    .almostEmpty(almostEmpty),
    .count(count),
    .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic p);
    validIn = v;
    dataIn  = d;
    pop     = p;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] q_m[$];
  int         cnt_m;
  logic [7:0] exp_d;
  logic       pa, pu, ps;

  initial begin
    reset    = 1'b1;
    validIn  = 1'b0;
    dataIn   = '0;
    pop      = 1'b0;
    afThresh = 3'd4;
    aeThresh = 3'd1;
    step(1'b1, 8'h99, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_err", error, 0);
    check("rst_vld", validOut, 0);
    check("rst_data", dataOut, 0);
    check("rst_ae", almostEmpty, 1);
    check("rst_af", almostFull, 0);

    // fill
    step(1'b1, 8'hA1, 1'b0);
    step(1'b1, 8'hA2, 1'b0);
    step(1'b1, 8'hA3, 1'b0);
    step(1'b1, 8'hA4, 1'b0);
    check("fill_count", count, 4);
    check("fill_full", full, 1);
    check("fill_empty", empty, 0);
    check("fill_err", error, 0);
    check("fill_af", almostFull, 1);

    // overflow
    step(1'b1, 8'hFF, 1'b0);
    check("ovf_err", error, 1);
    check("ovf_count", count, 4);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b1);
      check("ovf_pop_vld", validOut, 1);
      check("ovf_pop_data", dataOut, 32'hA1 + i);
      check("ovf_err_sticky", error, 1);
    end
    check("drain_empty", empty, 1);
    step(1'b0, 8'h00, 1'b0);
    check("idle_vld", validOut, 0);
    check("idle_hold", dataOut, 32'hA4);

    // push and pop together at full
    step(1'b1, 8'hB1, 1'b0);
    step(1'b1, 8'hB2, 1'b0);
    step(1'b1, 8'hB3, 1'b0);
    step(1'b1, 8'hB4, 1'b0);
    step(1'b1, 8'h55, 1'b1);
    check("sim_data", dataOut, 32'hB1);
    check("sim_vld", validOut, 1);
    check("sim_count", count, 4);
    check("sim_err", error, 1);
    step(1'b0, 8'h00, 1'b1);
    check("sim_p1", dataOut, 32'hB2);
    step(1'b0, 8'h00, 1'b1);
    check("sim_p2", dataOut, 32'hB3);
    step(1'b0, 8'h00, 1'b1);
    check("sim_p3", dataOut, 32'hB4);
    step(1'b0, 8'h00, 1'b1);
    check("sim_p4", dataOut, 32'h55);
    check("sim_empty", empty, 1);

    // pop on empty is ignored
    step(1'b0, 8'h00, 1'b1);
    check("epop_vld", validOut, 0);
    check("epop_count", count, 0);
    check("epop_hold", dataOut, 32'h55);

    // no bypass through an empty FIFO
    step(1'b1, 8'h33, 1'b1);
    check("edge_vld", validOut, 0);
    check("edge_count", count, 1);
    step(1'b0, 8'h00, 1'b1);
    check("edge_data", dataOut, 32'h33);
    check("edge_vld2", validOut, 1);
    check("edge_empty", empty, 1);

    // threshold change visible one cycle later
    afThresh = 3'd0;
    step(1'b0, 8'h00, 1'b0);
    check("thr_af0", almostFull, 1);
    aeThresh = 3'd0;
    afThresh = 3'd3;
    step(1'b0, 8'h00, 1'b0);
    check("thr_af3", almostFull, 0);
    check("thr_ae0", almostEmpty, 1);

    // wrapping stream with threshold flags
    aeThresh = 3'd1;
    cnt_m    = 0;
    for (int i = 0; i < 18; i++) begin
      pu = (i < 10);
      ps = (i % 3 == 2) || (i >= 10);
      pa = ps && (cnt_m > 0);
      if (pa) exp_d = q_m.pop_front();
      if (pu && (cnt_m < 4 || pa)) begin
        q_m.push_back(8'h60 + 8'(i));
        if (!pa) cnt_m++;
      end else if (pa) begin
        cnt_m--;
      end
      step(pu, 8'h60 + 8'(i), ps);
      check("wr_vld", validOut, 32'(pa));
      if (pa) check("wr_data", dataOut, 32'(exp_d));
      check("wr_count", count, cnt_m);
      check("wr_af", almostFull, 32'(cnt_m >= 3));
      check("wr_ae", almostEmpty, 32'(cnt_m <= 1));
    end

    // reset mid-run
    step(1'b1, 8'hC1, 1'b0);
    step(1'b1, 8'hC2, 1'b0);
    step(1'b1, 8'hC3, 1'b0);
    check("pre_rst_count", count, 3);
    reset = 1'b1;
    step(1'b1, 8'hC4, 1'b1);
    reset = 1'b0;
    check("mrst_count", count, 0);
    check("mrst_empty", empty, 1);
    check("mrst_vld", validOut, 0);
    check("mrst_data", dataOut, 0);
    check("mrst_err", error, 0);
    step(1'b0, 8'h00, 1'b1);
    check("mrst_pop_vld", validOut, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
